deser_stream: RTL and testbench
===============================

// Module: deser_stream
// PURPOSE
//  Parametrised serial-to-parallel converter: collects DATA_W single-bit samples
//  into one word and presents it on a valid/ready output port.
//  Next generation of our 16-bit deserializer. Adds configurable width and bit order,
//  an output holding register with backpressure, overrun reporting and an optional
//  partial-word flush. Sits between bit-level serial front-ends and word-level stream logic.
// PARAMETERS
//  DATA_W     16  output word width in bits; must be >= 2 (elaboration $error otherwise)
//  MSB_FIRST  1   1: first received bit lands in MSB; 0: first received bit lands in bit 0
//  LEN_W      $clog2(DATA_W+1)  width of deser_len_o (localparam, not overridable)
// PORTS
//  clk_i             in   1       clock, all logic on rising edge
//  arst_n_i          in   1       asynchronous reset, active low
//  data_i            in   1       serial data bit
//  data_val_i        in   1       data_i valid this cycle
//  flush_i           in   1       emit partial word (present only with DESER_FLUSH_EN)
//  deser_data_o      out  DATA_W  assembled word
//  deser_len_o       out  LEN_W   number of valid bits in deser_data_o (1..DATA_W)
//  deser_data_val_o  out  1       output word valid
//  deser_data_rdy_i  in   1       downstream accepts word when val & rdy
//  overrun_o         out  1       one-cycle pulse: completed word dropped
// BEHAVIOUR
//  - Reset (arst_n_i=0, async assert, sync release): bit counter=0, shift reg=0,
//    deser_data_o=0, deser_len_o=0, deser_data_val_o=0, overrun_o=0.
//  - Accumulator: on each data_val_i, shift data_i in per MSB_FIRST; counter +1.
//    Cycles without data_val_i hold state (gaps allowed, any length).
//  - Completion: edge that samples bit DATA_W completes the word; counter -> 0 on
//    that edge. The word is loaded into the output reg on the same edge, so
//    deser_data_val_o is high in the following cycle (latency 1 from last bit).
//  - Output reg is "free" if deser_data_val_o=0 or deser_data_rdy_i=1 this cycle.
//    Completion with free reg: load word, len=DATA_W, val=1 (back-to-back words
//    with no bubble when rdy held high).
//    Completion with reg busy (val=1, rdy=0): new word discarded, output reg
//    unchanged, overrun_o=1 for one cycle, counter still -> 0.
//  - Handshake: val stays high and data/len stay stable until val&rdy; after accept
//    with no new load, val -> 0 next cycle, data/len hold last value.
//  - rdy is ignored while val=0. Downstream must not depend on val to drive rdy.
//  - Bit order for a full word: MSB_FIRST=1 -> first bit at [DATA_W-1];
//    MSB_FIRST=0 -> first bit at [0].
//  - Counter wraps only via completion/flush, never overflows; width $clog2(DATA_W).
// CONFIGURATION
//  DESER_FLUSH_EN defined:
//   - flush_i present. Flush with k>0 bits collected (counting a bit sampled
//     in the same cycle) acts as completion with len=k.
//   - Partial word zero-padded: MSB_FIRST=1 -> bits left-aligned at
//     [DATA_W-1 -: k], low bits 0; MSB_FIRST=0 -> bits at [k-1:0], high bits 0.
//   - Flush with k=0 is ignored.
//   - Flush on the cycle the DATA_W-th bit arrives is a normal full word
//     (len=DATA_W).
//   - Busy-reg rules and overrun_o apply identically.
//  DESER_FLUSH_EN undefined:
//   - No flush_i port. deser_len_o is driven DATA_W whenever val=1
//     (0 after reset until the first load).
// TESTING
//  1 DATA_W=16,MSB_FIRST=1,rdy=1: bits of 16'hA5C3 MSB first, data_val_i gaps of 0-3 cycles
//    -> single val pulse 1 cycle after last bit, data=16'hA5C3, len=16.
//  2 MSB_FIRST=0: send 16'hA5C3 LSB first -> data=16'hA5C3.
//    Then 32 bits with rdy=1 continuously -> two consecutive val cycles, no bubble.
//  3 rdy=0: send word 16'h1234 then 16'hFFFF -> overrun_o pulses on 2nd completion;
//    output holds 16'h1234 until rdy=1, then val drops; next word starts clean.
//  4 completion of 16'h00FF on the same edge rdy accepts 16'h1234 -> 16'h00FF loaded,
//    val stays 1, no overrun.
//  5 DESER_FLUSH_EN, MSB_FIRST=1: bits 1,0,1,1,0 then flush_i -> data=16'hB000, len=5;
//    MSB_FIRST=0 same bits -> data=16'h000D, len=5; flush with 0 bits -> no val.
//  6 reset asserted after 7 bits and mid-handshake (val=1,rdy=0) -> all outputs 0 at once;
//    after release a full word 16'h5A5A is received correctly with len=16.

Source files
------------

// File: rtl/deser_stream.sv
// Serial-to-parallel converter: packs DATA_W bits into a word behind a valid/ready holding register.
// Optional partial-word flush is compiled in with `define DESER_FLUSH_EN.
module deser_stream #(
    parameter  int DATA_W    = 16,
    parameter  bit MSB_FIRST = 1'b1,
    localparam int LEN_W     = $clog2(DATA_W + 1)
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              data_i,
    input  logic              data_val_i,
`ifdef DESER_FLUSH_EN
    input  logic              flush_i,
`endif
    output logic [DATA_W-1:0] deser_data_o,
    output logic [LEN_W-1:0]  deser_len_o,
    output logic              deser_data_val_o,
    input  logic              deser_data_rdy_i,
    output logic              overrun_o
);

    localparam int CNT_W = $clog2(DATA_W);

    generate
        if (DATA_W < 2) begin : g_bad_width
            $error("deser_stream: DATA_W must be >= 2");
        end
    endgenerate

    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_sr;
    logic [DATA_W-1:0] w_sr_nxt;
    logic [DATA_W-1:0] w_word;
    logic [LEN_W-1:0]  w_len;
    logic              w_full;
    logic              w_done;
    logic              w_free;
`ifdef DESER_FLUSH_EN
    logic [LEN_W-1:0]  w_k;
    logic [LEN_W-1:0]  w_shamt;
`endif

    always_comb begin
        w_sr_nxt = r_sr;
        if (data_val_i) begin
            w_sr_nxt = MSB_FIRST ? {r_sr[DATA_W-2:0], data_i} : {data_i, r_sr[DATA_W-1:1]};
        end
    end

    assign w_full = data_val_i && (r_cnt == CNT_W'(DATA_W - 1));
    assign w_free = !deser_data_val_o || deser_data_rdy_i;

`ifdef DESER_FLUSH_EN
    // Stale bits of the previous word sit on the far side of the shift reg;
    // aligning by DATA_W-k pushes them out and zero-pads. A full word gets shift 0.
    assign w_k     = LEN_W'(r_cnt) + LEN_W'(data_val_i);
    assign w_shamt = LEN_W'(DATA_W) - w_k;
    assign w_done  = w_full || (flush_i && (w_k != '0));
    assign w_len   = w_k;
    assign w_word  = MSB_FIRST ? (w_sr_nxt << w_shamt) : (w_sr_nxt >> w_shamt);
`else
    assign w_done  = w_full;
    assign w_len   = LEN_W'(DATA_W);
    assign w_word  = w_sr_nxt;
`endif

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_cnt <= '0;
            r_sr  <= '0;
        end else begin
            r_sr <= w_sr_nxt;
            if (w_done) begin
                r_cnt <= '0;
            end else if (data_val_i) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Holding register: a busy slot drops the new word and flags overrun.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            deser_data_o     <= '0;
            deser_len_o      <= '0;
            deser_data_val_o <= 1'b0;
            overrun_o        <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (w_done && w_free) begin
                deser_data_o     <= w_word;
                deser_len_o      <= w_len;
                deser_data_val_o <= 1'b1;
            end else begin
                if (w_done) begin
                    overrun_o <= 1'b1;
                end
                if (deser_data_val_o && deser_data_rdy_i) begin
                    deser_data_val_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_deser_stream.sv
// Directed bench: one MSB-first and one LSB-first instance fed the same serial stream.
module tb_deser_stream;

    logic clk = 1'b0;
    logic arst_n;
    logic din, dval, rdy;
`ifdef DESER_FLUSH_EN
    logic flush;
`endif
    logic [15:0] dm, dl;
    logic [4:0]  lm, ll;
    logic        vm, vl, om, ol;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    deser_stream #(.DATA_W(16), .MSB_FIRST(1'b1)) u_msb (
        .clk_i(clk), .arst_n_i(arst_n), .data_i(din), .data_val_i(dval),
`ifdef DESER_FLUSH_EN
        .flush_i(flush),
`endif
        .deser_data_o(dm), .deser_len_o(lm), .deser_data_val_o(vm),
        .deser_data_rdy_i(rdy), .overrun_o(om)
    );

    deser_stream #(.DATA_W(16), .MSB_FIRST(1'b0)) u_lsb (
        .clk_i(clk), .arst_n_i(arst_n), .data_i(din), .data_val_i(dval),
`ifdef DESER_FLUSH_EN
        .flush_i(flush),
`endif
        .deser_data_o(dl), .deser_len_o(ll), .deser_data_val_o(vl),
        .deser_data_rdy_i(rdy), .overrun_o(ol)
    );

    typedef struct {
        logic [15:0] word;
        bit          lsb_first;
        int          gap;      // -1: gap of (bit index % 4) cycles
        logic [15:0] exp_m;
        logic [15:0] exp_l;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_range(input logic [15:0] w, input bit lsb_first, input int gap,
                              input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            int g;
            g = (gap < 0) ? (i % 4) : gap;
            if (i > 0) repeat (g) tick();
            din  = lsb_first ? w[i] : w[15-i];
            dval = 1'b1;
            tick();
            dval = 1'b0;
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " data_m"}, dm, 0);
        chk({nm, " len_m"}, lm, 0);
        chk({nm, " val_m"}, vm, 0);
        chk({nm, " ovr_m"}, om, 0);
        chk({nm, " data_l"}, dl, 0);
        chk({nm, " val_l"}, vl, 0);
    endtask

    initial begin
        vecs[0] = '{16'hA5C3, 1'b0, -1, 16'hA5C3, 16'hC3A5};
        vecs[1] = '{16'hA5C3, 1'b1,  0, 16'hC3A5, 16'hA5C3};
        vecs[2] = '{16'h1234, 1'b0,  1, 16'h1234, 16'h2C48};
        vecs[3] = '{16'h00FF, 1'b1,  0, 16'hFF00, 16'h00FF};

        arst_n = 1'b0; din = 1'b0; dval = 1'b0; rdy = 1'b1;
`ifdef DESER_FLUSH_EN
        flush = 1'b0;
`endif
        #12;
        chk_zero("reset");
        @(negedge clk) arst_n = 1'b1;
        tick();

        // table: full words, various orders and gaps, rdy held high
        foreach (vecs[e]) begin
            rdy = 1'b1;
            send_range(vecs[e].word, vecs[e].lsb_first, vecs[e].gap, 0, 14);
            chk($sformatf("v%0d early val_m", e), vm, 0);
            chk($sformatf("v%0d early val_l", e), vl, 0);
            send_range(vecs[e].word, vecs[e].lsb_first, vecs[e].gap, 15, 15);
            chk($sformatf("v%0d val_m", e), vm, 1);
            chk($sformatf("v%0d val_l", e), vl, 1);
            chk($sformatf("v%0d data_m", e), dm, vecs[e].exp_m);
            chk($sformatf("v%0d data_l", e), dl, vecs[e].exp_l);
            chk($sformatf("v%0d len_m", e), lm, 16);
            chk($sformatf("v%0d len_l", e), ll, 16);
            chk($sformatf("v%0d ovr_m", e), om, 0);
            tick();
            chk($sformatf("v%0d drop val_m", e), vm, 0);
            chk($sformatf("v%0d hold data_m", e), dm, vecs[e].exp_m);
            chk($sformatf("v%0d hold len_m", e), lm, 16);
        end

        // 32 bits back to back
        send_range(16'hF00F, 1'b0, 0, 0, 15);
        chk("b2b w1 val", vm, 1);
        chk("b2b w1 data", dm, 16'hF00F);
        send_range(16'h0FF0, 1'b0, 0, 0, 15);
        chk("b2b w2 val", vm, 1);
        chk("b2b w2 data_m", dm, 16'h0FF0);
        chk("b2b w2 data_l", dl, 16'h0FF0);
        tick();

        // overrun while holding register is busy
        rdy = 1'b0;
        send_range(16'h1234, 1'b0, 0, 0, 15);
        chk("ovr w1 val", vm, 1);
        chk("ovr w1 data", dm, 16'h1234);
        send_range(16'hFFFF, 1'b0, 0, 0, 15);
        chk("ovr pulse_m", om, 1);
        chk("ovr pulse_l", ol, 1);
        chk("ovr hold data_m", dm, 16'h1234);
        chk("ovr hold data_l", dl, 16'h2C48);
        chk("ovr hold val", vm, 1);
        tick();
        chk("ovr pulse end", om, 0);
        chk("ovr still val", vm, 1);
        rdy = 1'b1;
        tick();
        chk("ovr accepted val", vm, 0);
        chk("ovr accepted data", dm, 16'h1234);
        send_range(16'hA5C3, 1'b0, 0, 0, 15);
        chk("ovr clean data", dm, 16'hA5C3);
        chk("ovr clean val", vm, 1);
        tick();

        // completion on the same edge the held word is accepted
        rdy = 1'b0;
        send_range(16'h1234, 1'b0, 0, 0, 15);
        send_range(16'h00FF, 1'b0, 0, 0, 14);
        rdy = 1'b1;
        send_range(16'h00FF, 1'b0, 0, 15, 15);
        chk("acc+load val", vm, 1);
        chk("acc+load data_m", dm, 16'h00FF);
        chk("acc+load data_l", dl, 16'hFF00);
        chk("acc+load ovr", om, 0);
        tick();
        chk("acc+load drop", vm, 0);

`ifdef DESER_FLUSH_EN
        // partial flush after 5 bits 1,0,1,1,0
        send_range(16'hB000, 1'b0, 0, 0, 4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush val", vm, 1);
        chk("flush data_m", dm, 16'hB000);
        chk("flush len_m", lm, 5);
        chk("flush data_l", dl, 16'h000D);
        chk("flush len_l", ll, 5);
        tick();
        chk("flush drop", vm, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush empty val_m", vm, 0);
        chk("flush empty val_l", vl, 0);
        // flush sampled with the 5th bit
        send_range(16'hB000, 1'b0, 0, 0, 3);
        flush = 1'b1;
        send_range(16'hB000, 1'b0, 0, 4, 4);
        flush = 1'b0;
        chk("flush same-cycle data", dm, 16'hB000);
        chk("flush same-cycle len", lm, 5);
        tick();
        // flush with the 16th bit is a normal full word
        send_range(16'hA5C3, 1'b0, 0, 0, 14);
        flush = 1'b1;
        send_range(16'hA5C3, 1'b0, 0, 15, 15);
        flush = 1'b0;
        chk("flush full data", dm, 16'hA5C3);
        chk("flush full len", lm, 16);
        tick();
        // flush into a busy register
        rdy = 1'b0;
        send_range(16'h1234, 1'b0, 0, 0, 15);
        send_range(16'hB000, 1'b0, 0, 0, 2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush busy ovr", om, 1);
        chk("flush busy data", dm, 16'h1234);
        rdy = 1'b1;
        tick();
        tick();
        chk("flush busy counter cleared val", vm, 0);
`else
        chk("no-flush len", lm, 16);
`endif

        // async reset mid-word and mid-handshake
        rdy = 1'b0;
        send_range(16'h1234, 1'b0, 0, 0, 15);
        send_range(16'h5A5A, 1'b0, 0, 0, 6);
        chk("pre-reset val", vm, 1);
        #2 arst_n = 1'b0;
        #1;
        chk_zero("midreset");
        @(negedge clk) arst_n = 1'b1;
        tick();
        rdy = 1'b1;
        send_range(16'h5A5A, 1'b0, 0, 0, 15);
        chk("post-reset val", vm, 1);
        chk("post-reset data_m", dm, 16'h5A5A);
        chk("post-reset data_l", dl, 16'h5A5A);
        chk("post-reset len", lm, 16);
        tick();
        chk("post-reset drop", vm, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
